// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants for the 4-digit 7-segment frame multiplexer.
//               It holds the digit count, the blank patterns for the anodes and
//               segments, and the hex-to-segment table. Segments are active-low
//               and ordered {g,f,e,d,c,b,a}.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Entry n holds the pattern for hex digit n. Entry 0 is the rightmost element.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_decoder
// Description : Combinational decoder from a 4-bit nibble to active-low
//               7-segment code {g,f,e,d,c,b,a}.
// Ports       : i_nibble [3:0] - hex digit
//               o_seg    [6:0] - active-low segment pattern
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = hex_to_seg(i_nibble);

endmodule
`default_nettype wire

// File: rtl/seg7_frame_mux.sv
`default_nettype none
// ============================================================================
// Module      : seg7_frame_mux
// Description : Captures a 16-bit value through a valid strobe and drives it
//               as 4 hex digits on a common-anode 7-segment display. New values
//               take effect only at frame boundaries, so a digit never shows a
//               mix of old and new values. All anodes are held off at the start
//               of each digit slot to suppress ghosting. All pins are registered.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               enable           - display on; 0 blanks and parks the scan
//               value_in [15:0]  - value; digit k = value_in[4k+3:4k]
//               value_valid      - one-cycle capture strobe
//               dp_in [3:0]      - per-digit decimal point, active-high
//               seg [6:0]        - {g,f,e,d,c,b,a}, active-low
//               dp               - decimal point, active-low
//               an [3:0]         - digit anodes, active-low
// Options     : SEG7_LZ_BLANK_EN - when defined, leading-zero digits are blanked
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_frame_mux
    import seg7_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int REFRESH_HZ = 1000,
    parameter int BLANK_CYC  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] value_in,
    input  logic        value_valid,
    input  logic [3:0]  dp_in,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int DIV   = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] c_blank_end = CNT_W'(BLANK_CYC);

    generate
        if (DIV <= BLANK_CYC + 1) begin : g_cfg_check
            $error("seg7_frame_mux: DIV must exceed BLANK_CYC+1");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [15:0]      r_shown;
    logic [3:0]       r_shown_dp;
    logic [15:0]      r_pend;
    logic [3:0]       r_pend_dp;
    logic             r_pend_vld;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;

    logic             w_frame_end;
    logic             w_blank;
    logic [3:0]       w_nibble;
    logic [6:0]       w_hex_seg;
    logic             w_lz_blank;
    logic [6:0]       w_digit_seg;

    // Last cycle of the digit-3 slot. Shown state is swapped only here.
    assign w_frame_end = enable && (r_cnt == c_cnt_last) && (r_idx == 2'd3);

    assign w_blank  = !enable || (r_cnt < c_blank_end);
    assign w_nibble = r_shown[{r_idx, 2'b00} +: 4];

    seg7_hex_decoder u_hex_decoder (
        .i_nibble (w_nibble),
        .o_seg    (w_hex_seg)
    );

`ifdef SEG7_LZ_BLANK_EN
    // Digit k blanks when it and every more-significant nibble are zero.
    // Digit 0 is always lit, so a zero value still shows "0".
    always_comb begin
        w_lz_blank = 1'b0;
        case (r_idx)
            2'd3:    w_lz_blank = (r_shown[15:12] == 4'h0);
            2'd2:    w_lz_blank = (r_shown[15:8]  == 8'h00);
            2'd1:    w_lz_blank = (r_shown[15:4]  == 12'h000);
            default: w_lz_blank = 1'b0;
        endcase
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    assign w_digit_seg = w_lz_blank ? SEG_OFF : w_hex_seg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_idx      <= 2'd0;
            r_shown    <= 16'h0000;
            r_shown_dp <= 4'h0;
            r_pend     <= 16'h0000;
            r_pend_dp  <= 4'h0;
            r_pend_vld <= 1'b0;
            r_an       <= AN_OFF;
            r_seg      <= SEG_OFF;
            r_dp       <= 1'b1;
        end else begin
            // Scan prescaler and digit index
            if (!enable) begin
                r_cnt <= '0;
                r_idx <= 2'd0;
            end else if (r_cnt == c_cnt_last) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Capture. The last strobe before a swap wins.
            if (value_valid) begin
                r_pend    <= value_in;
                r_pend_dp <= dp_in;
            end

            // A swap consumes the pending value. While disabled, a fresh
            // strobe re-arms the pending flag so that the value reaches the
            // display on the following cycle.
            if (w_frame_end) begin
                r_pend_vld <= 1'b0;
            end else if (value_valid) begin
                r_pend_vld <= 1'b1;
            end else if (!enable) begin
                r_pend_vld <= 1'b0;
            end

            // Update of the shown value. A strobe in the boundary cycle goes
            // straight to the display, bypassing the pending register.
            if (w_frame_end) begin
                if (value_valid) begin
                    r_shown    <= value_in;
                    r_shown_dp <= dp_in;
                end else if (r_pend_vld) begin
                    r_shown    <= r_pend;
                    r_shown_dp <= r_pend_dp;
                end
            end else if (!enable && r_pend_vld) begin
                r_shown    <= r_pend;
                r_shown_dp <= r_pend_dp;
            end

            // Registered pin drive
            if (w_blank) begin
                r_an  <= AN_OFF;
                r_seg <= SEG_OFF;
                r_dp  <= 1'b1;
            end else begin
                r_an  <= ~(4'b0001 << r_idx);
                r_seg <= w_digit_seg;
                r_dp  <= ~r_shown_dp[r_idx];
            end
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_seg7_frame_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_frame_mux
// Description : Self-checking bench for seg7_frame_mux with CLK_HZ=1000,
//               REFRESH_HZ=25 and BLANK_CYC=2, which gives 10 cycles per digit
//               slot. The bench follows the scan position (b_idx, b_cnt) from
//               the reset and enable inputs it drives. Output pins lag that
//               position by one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_frame_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] value_in;
    logic        value_valid;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int n_vec = 0;
    int n_bad = 0;
    int b_cnt = 0;
    int b_idx = 0;

`ifdef SEG7_LZ_BLANK_EN
    localparam logic [6:0] ZLEAD = 7'h7F;
`else
    localparam logic [6:0] ZLEAD = 7'b1000000;
`endif

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dpi;
        int          dig;
        logic [3:0]  ean;
        logic [6:0]  eseg;
        logic        edp;
    } vec_t;

    vec_t vecs[16];

    seg7_frame_mux #(
        .CLK_HZ     (1000),
        .REFRESH_HZ (25),
        .BLANK_CYC  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .value_in    (value_in),
        .value_valid (value_valid),
        .dp_in       (dp_in),
        .seg         (seg),
        .dp          (dp),
        .an          (an)
    );

    always #5 clk = ~clk;

    // One clock: advance the scan-position tracker at the edge, return at negedge.
    task automatic tick();
        @(posedge clk);
        if (rst || !enable) begin
            b_cnt = 0;
            b_idx = 0;
        end else if (b_cnt == 9) begin
            b_cnt = 0;
            b_idx = (b_idx + 1) % 4;
        end else begin
            b_cnt = b_cnt + 1;
        end
        @(negedge clk);
    endtask

    task automatic strobe(input logic [15:0] v, input logic [3:0] d);
        value_in    = v;
        dp_in       = d;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
    endtask

    task automatic goto_pos(input int i, input int c);
        int k;
        k = 0;
        while (!(b_idx == i && b_cnt == c) && k < 200) begin
            tick();
            k++;
        end
        if (!(b_idx == i && b_cnt == c)) begin
            n_vec++;
            n_bad++;
            $display("FAIL goto_pos(%0d,%0d): position never reached", i, c);
        end
    endtask

    // Lands on (0,0), the first cycle after a frame boundary.
    task automatic next_frame();
        goto_pos(3, 9);
        tick();
    endtask

    task automatic check(input string name, input logic [3:0] ean,
                         input logic [6:0] eseg, input logic edp);
        n_vec++;
        if (an !== ean || seg !== eseg || dp !== edp) begin
            n_bad++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                     name, an, seg, dp, ean, eseg, edp);
        end
    endtask

    initial begin
        vecs[0]  = '{16'h1234, 4'b0000, 0, 4'b1110, 7'b0011001, 1'b1};
        vecs[1]  = '{16'h1234, 4'b0000, 1, 4'b1101, 7'b0110000, 1'b1};
        vecs[2]  = '{16'h1234, 4'b0000, 2, 4'b1011, 7'b0100100, 1'b1};
        vecs[3]  = '{16'h1234, 4'b0000, 3, 4'b0111, 7'b1111001, 1'b1};
        vecs[4]  = '{16'hABCD, 4'b0101, 0, 4'b1110, 7'b0100001, 1'b0};
        vecs[5]  = '{16'hABCD, 4'b0101, 1, 4'b1101, 7'b1000110, 1'b1};
        vecs[6]  = '{16'hABCD, 4'b0101, 2, 4'b1011, 7'b0000011, 1'b0};
        vecs[7]  = '{16'hABCD, 4'b0101, 3, 4'b0111, 7'b0001000, 1'b1};
        vecs[8]  = '{16'h9E70, 4'b1000, 0, 4'b1110, 7'b1000000, 1'b1};
        vecs[9]  = '{16'h9E70, 4'b1000, 1, 4'b1101, 7'b1111000, 1'b1};
        vecs[10] = '{16'h9E70, 4'b1000, 2, 4'b1011, 7'b0000110, 1'b1};
        vecs[11] = '{16'h9E70, 4'b1000, 3, 4'b0111, 7'b0010000, 1'b0};
        vecs[12] = '{16'h5C86, 4'b0010, 0, 4'b1110, 7'b0000010, 1'b1};
        vecs[13] = '{16'h5C86, 4'b0010, 1, 4'b1101, 7'b0000000, 1'b0};
        vecs[14] = '{16'h5C86, 4'b0010, 2, 4'b1011, 7'b1000110, 1'b1};
        vecs[15] = '{16'h5C86, 4'b0010, 3, 4'b0111, 7'b0010010, 1'b1};

        rst         = 1'b1;
        enable      = 1'b1;
        value_valid = 1'b0;
        value_in    = 16'h0000;
        dp_in       = 4'h0;
        @(negedge clk);
        repeat (3) tick();
        check("reset_pins", 4'b1111, 7'h7F, 1'b1);
        rst = 1'b0;

        // The first frame shows the reset value 0.
        goto_pos(0, 5);
        check("reset_shown_zero", 4'b1110, 7'b1000000, 1'b1);

        // Scan with 0x1234, including the blank window
        strobe(16'h1234, 4'b0000);
        next_frame();
        tick();
        check("scan_blank_cnt0", 4'b1111, 7'h7F, 1'b1);
        tick();
        check("scan_blank_cnt1", 4'b1111, 7'h7F, 1'b1);
        tick();
        check("scan_d0_first_lit", 4'b1110, 7'b0011001, 1'b1);
        goto_pos(1, 1);
        check("scan_d1_blank", 4'b1111, 7'h7F, 1'b1);
        goto_pos(1, 3);
        check("scan_d1", 4'b1101, 7'b0110000, 1'b1);
        goto_pos(2, 3);
        check("scan_d2", 4'b1011, 7'b0100100, 1'b1);
        goto_pos(3, 3);
        check("scan_d3", 4'b0111, 7'b1111001, 1'b1);

        // Mid-frame strobe must wait for the frame boundary.
        goto_pos(1, 5);
        strobe(16'hABCD, 4'b0101);
        goto_pos(2, 5);
        check("sync_d2_old", 4'b1011, 7'b0100100, 1'b1);
        goto_pos(3, 5);
        check("sync_d3_old", 4'b0111, 7'b1111001, 1'b1);
        goto_pos(0, 5);
        check("sync_d0_new", 4'b1110, 7'b0100001, 1'b0);

        // Strobe in the boundary cycle bypasses an older pending value.
        goto_pos(2, 5);
        strobe(16'h5555, 4'b0000);
        goto_pos(3, 9);
        strobe(16'h00F0, 4'b0000);
        goto_pos(1, 5);
        check("bypass_d1_F", 4'b1101, 7'b0001110, 1'b1);
        goto_pos(3, 5);
        check("bypass_d3_zero", 4'b0111, ZLEAD, 1'b1);
        goto_pos(1, 5);
        check("bypass_no_stale", 4'b1101, 7'b0001110, 1'b1);

        // Last write wins
        goto_pos(0, 5);
        strobe(16'h1111, 4'b0000);
        goto_pos(2, 5);
        strobe(16'h2222, 4'b0000);
        goto_pos(0, 5);
        check("lww_d0", 4'b1110, 7'b0100100, 1'b1);
        goto_pos(3, 5);
        check("lww_d3", 4'b0111, 7'b0100100, 1'b1);

        // Table-driven vectors
        for (int i = 0; i < 16; i++) begin
            if (i == 0 || vecs[i].val != vecs[i-1].val || vecs[i].dpi != vecs[i-1].dpi) begin
                strobe(vecs[i].val, vecs[i].dpi);
                next_frame();
            end
            goto_pos(vecs[i].dig, 5);
            check($sformatf("vec%0d_%h_d%0d", i, vecs[i].val, vecs[i].dig),
                  vecs[i].ean, vecs[i].eseg, vecs[i].edp);
        end

        // Drop enable mid-frame. A capture while disabled reaches the display.
        goto_pos(2, 5);
        enable = 1'b0;
        tick();
        check("dis_blank_next", 4'b1111, 7'h7F, 1'b1);
        strobe(16'h3456, 4'b0001);
        tick();
        tick();
        check("dis_still_blank", 4'b1111, 7'h7F, 1'b1);
        enable = 1'b1;
        tick();
        check("reen_blank0", 4'b1111, 7'h7F, 1'b1);
        tick();
        check("reen_blank1", 4'b1111, 7'h7F, 1'b1);
        tick();
        check("reen_d0_lit", 4'b1110, 7'b0000010, 1'b0);

        // Reset mid-frame discards a pending value.
        goto_pos(1, 5);
        strobe(16'h7777, 4'b0000);
        goto_pos(2, 3);
        rst = 1'b1;
        tick();
        check("rst_mid_pins", 4'b1111, 7'h7F, 1'b1);
        rst = 1'b0;
        goto_pos(0, 5);
        check("rst_mid_shown0", 4'b1110, 7'b1000000, 1'b1);
        next_frame();
        goto_pos(0, 5);
        check("rst_pending_lost", 4'b1110, 7'b1000000, 1'b1);
        goto_pos(1, 5);
        check("rst_pending_lost_d1", 4'b1101, ZLEAD, 1'b1);

        // Leading zeros (blanked only when the option is built in)
        strobe(16'h0042, 4'b0001);
        next_frame();
        goto_pos(0, 5);
        check("lz_d0_2_dp", 4'b1110, 7'b0100100, 1'b0);
        goto_pos(1, 5);
        check("lz_d1_4", 4'b1101, 7'b0011001, 1'b1);
        goto_pos(2, 5);
        check("lz_d2", 4'b1011, ZLEAD, 1'b1);
        goto_pos(3, 5);
        check("lz_d3", 4'b0111, ZLEAD, 1'b1);
        strobe(16'h0000, 4'b0000);
        next_frame();
        goto_pos(0, 5);
        check("lz_zero_d0", 4'b1110, 7'b1000000, 1'b1);
        goto_pos(1, 5);
        check("lz_zero_d1", 4'b1101, ZLEAD, 1'b1);
        goto_pos(3, 5);
        check("lz_zero_d3", 4'b0111, ZLEAD, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
